// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit FIFO front-ends.
package uart_pkg;

  // Receiver/transmitter frame state encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // 50 MHz / 115200 baud.
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

  // 8N1 framing: one stop bit.
  localparam int unsigned STOP_BITS = 1;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next-state: shift the pin through the two stages.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchroniser flops, forced to the line's idle level on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_fifo_writer.sv
// 8N1 UART receiver that pushes each good byte into a FIFO write port.
module uart_rx_fifo_writer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 CLOCK_50,
  input  logic                 RST,
  input  logic                 rx,
  input  logic                 full,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 write,
  output logic                 framing_error,
  output logic                 overrun,
  input  logic                 clear_errors,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] HALF_TERM = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_TERM = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

  logic rx_s;

  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 write_q, write_d;
  logic                 fe_q, fe_d;
  logic                 ov_q, ov_d;
  logic                 busy_q, busy_d;
  logic                 sample;
  logic                 fe_set, ov_set;

  // Bring the pin into the clock domain; idle-high reset value.
  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .clk(CLOCK_50),
    .rst(RST),
    .d  (rx),
    .q  (rx_s)
  );

  // Frame FSM next-state, sampling, byte assembly and sticky flags.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    write_d = 1'b0;
    fe_d    = fe_q;
    ov_d    = ov_q;
    fe_set  = 1'b0;
    ov_set  = 1'b0;
    sample  = (cnt_q == ((state_q == START) ? HALF_TERM : FULL_TERM));

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (sample) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (sample) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == LAST_IDX) state_d = STOP;
          else                   idx_d   = idx_q + IDX_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (sample) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (!rx_s) begin
            fe_set = 1'b1;
          end else if (full) begin
            ov_set = 1'b1;
          end else begin
            write_d = 1'b1;
            data_d  = shift_q;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A new error in the same cycle as a clear request still latches.
    if (clear_errors) begin
      fe_d = 1'b0;
      ov_d = 1'b0;
    end
    if (fe_set) fe_d = 1'b1;
    if (ov_set) ov_d = 1'b1;

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any frame in flight.
  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      write_q <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      write_q <= write_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
      busy_q  <= busy_d;
    end
  end

  assign data_out      = data_q;
  assign write         = write_q;
  assign framing_error = fe_q;
  assign overrun       = ov_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_uart_rx_fifo_writer.sv
// Scoreboard bench: stimulus queues expected FIFO pushes, a monitor checks them.
module tb_uart_rx_fifo_writer;

  localparam int unsigned CPB = 8;

  logic       CLOCK_50;
  logic       RST;
  logic       rx;
  logic       full;
  logic [7:0] data_out;
  logic       write;
  logic       framing_error;
  logic       overrun;
  logic       clear_errors;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  uart_rx_fifo_writer #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (8)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .RST          (RST),
    .rx           (rx),
    .full         (full),
    .data_out     (data_out),
    .write        (write),
    .framing_error(framing_error),
    .overrun      (overrun),
    .clear_errors (clear_errors),
    .busy         (busy)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    idle(CPB);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_val);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_val);
    rx = 1'b1;
  endtask

  // Monitor: every write strobe must match the oldest queued byte.
  always @(negedge CLOCK_50) begin
    if (write) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got data 0x%0h expected no write at %0t", data_out, $time);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          n_fail++;
          $display("FAIL write_data: got 0x%0h expected 0x%0h at %0t", data_out, e, $time);
        end
      end
    end
  end

  initial begin
    RST          = 1'b1;
    rx           = 1'b1;
    full         = 1'b0;
    clear_errors = 1'b0;
    idle(3);
    RST = 1'b0;

    check("reset_write", 32'(write), 32'd0);
    check("reset_data", 32'(data_out), 32'd0);
    check("reset_fe", 32'(framing_error), 32'd0);
    check("reset_ov", 32'(overrun), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    idle(4);

    // Single good byte.
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    check("a5_busy_idle", 32'(busy), 32'd0);
    idle(4);
    check("a5_data_hold", 32'(data_out), 32'hA5);
    check("a5_fe", 32'(framing_error), 32'd0);
    check("a5_ov", 32'(overrun), 32'd0);

    // Back-to-back frames with no idle gap.
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(4);
    check("b2b_drained", 32'(exp_q.size()), 32'd0);

    // Two-cycle start glitch is rejected.
    rx = 1'b0;
    idle(2);
    rx = 1'b1;
    idle(2);
    check("glitch_busy_mid", 32'(busy), 32'd1);
    idle(4);
    check("glitch_busy_end", 32'(busy), 32'd0);
    check("glitch_fe", 32'(framing_error), 32'd0);
    check("glitch_ov", 32'(overrun), 32'd0);
    idle(8);

    // Framing error, then a good byte, then clear.
    send_frame(8'h3C, 1'b0);
    idle(20);
    check("fe_set", 32'(framing_error), 32'd1);
    exp_q.push_back(8'h42);
    send_frame(8'h42, 1'b1);
    idle(4);
    check("fe_sticky", 32'(framing_error), 32'd1);
    clear_errors = 1'b1;
    idle(1);
    clear_errors = 1'b0;
    check("fe_cleared", 32'(framing_error), 32'd0);
    idle(4);

    // Overrun while full, then a good byte once full drops.
    full = 1'b1;
    send_frame(8'h55, 1'b1);
    idle(4);
    full = 1'b0;
    check("ov_set", 32'(overrun), 32'd1);
    check("ov_no_fe", 32'(framing_error), 32'd0);
    exp_q.push_back(8'h66);
    send_frame(8'h66, 1'b1);
    idle(4);
    check("ov_sticky", 32'(overrun), 32'd1);
    check("data_66", 32'(data_out), 32'h66);

    // Reset during data bit 3 of 0x81 aborts the frame.
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b0);
    rx = 1'b0;
    idle(3);
    RST = 1'b1;
    idle(1);
    RST = 1'b0;
    rx  = 1'b1;
    check("rst_write", 32'(write), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_fe", 32'(framing_error), 32'd0);
    check("rst_ov", 32'(overrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    idle(30);
    check("rst_stays_idle", 32'(busy), 32'd0);

    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1);
    idle(10);
    check("final_drained", 32'(exp_q.size()), 32'd0);
    check("final_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
